// File: rtl/disp_pkg.sv
// Shared types for the display byte sequencer: state encoding, init length and init ROM.
// The init ROM and INIT states exist only when DISP_INIT_SEQ_EN is defined.
package disp_pkg;

    localparam logic [2:0] ENC_RST_HOLD  = 3'd0;
    localparam logic [2:0] ENC_RST_WAIT  = 3'd1;
    localparam logic [2:0] ENC_INIT_SEND = 3'd2;
    localparam logic [2:0] ENC_INIT_WAIT = 3'd3;
    localparam logic [2:0] ENC_READY     = 3'd4;
    localparam logic [2:0] ENC_FB_FETCH  = 3'd5;
    localparam logic [2:0] ENC_FB_SEND   = 3'd6;
    localparam logic [2:0] ENC_FB_WAIT   = 3'd7;

    typedef enum logic [2:0] {
        RST_HOLD  = ENC_RST_HOLD,
        RST_WAIT  = ENC_RST_WAIT,
`ifdef DISP_INIT_SEQ_EN
        INIT_SEND = ENC_INIT_SEND,
        INIT_WAIT = ENC_INIT_WAIT,
`endif
        READY     = ENC_READY,
        FB_FETCH  = ENC_FB_FETCH,
        FB_SEND   = ENC_FB_SEND,
        FB_WAIT   = ENC_FB_WAIT
    } state_t;

    localparam int INIT_LEN = 25;

`ifdef DISP_INIT_SEQ_EN
    // SSD1306 128x64 bring-up: display off, clocking, mux, offset, charge pump,
    // horizontal addressing, remap, COM config, contrast, precharge, VCOMH, display on.
    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    init_rom = 8'hAE;
            5'd1:    init_rom = 8'hD5;
            5'd2:    init_rom = 8'h80;
            5'd3:    init_rom = 8'hA8;
            5'd4:    init_rom = 8'h3F;
            5'd5:    init_rom = 8'hD3;
            5'd6:    init_rom = 8'h00;
            5'd7:    init_rom = 8'h40;
            5'd8:    init_rom = 8'h8D;
            5'd9:    init_rom = 8'h14;
            5'd10:   init_rom = 8'h20;
            5'd11:   init_rom = 8'h00;
            5'd12:   init_rom = 8'hA1;
            5'd13:   init_rom = 8'hC8;
            5'd14:   init_rom = 8'hDA;
            5'd15:   init_rom = 8'h12;
            5'd16:   init_rom = 8'h81;
            5'd17:   init_rom = 8'hCF;
            5'd18:   init_rom = 8'hD9;
            5'd19:   init_rom = 8'hF1;
            5'd20:   init_rom = 8'hDB;
            5'd21:   init_rom = 8'h40;
            5'd22:   init_rom = 8'hA4;
            5'd23:   init_rom = 8'hA6;
            5'd24:   init_rom = 8'hAF;
            default: init_rom = 8'h00;
        endcase
    endfunction
`endif

endpackage

// File: rtl/disp_stream_ctrl.sv
// Byte sequencer feeding spi_master: display reset pulse, optional init commands
// (DISP_INIT_SEQ_EN), then one framebuffer stream per frame request.
//
// state     | meaning
// RST_HOLD  | disp_res_n low for RST_CYCLES
// RST_WAIT  | disp_res_n high, settle for RST_CYCLES
// INIT_SEND | launch init command byte idx (dc=0)
// INIT_WAIT | wait spi_done for the command byte
// READY     | idle; accept frame_req or pending request
// FB_FETCH  | framebuffer read latency cycle
// FB_SEND   | launch framebuffer byte (dc=1)
// FB_WAIT   | wait spi_done for the data byte
module disp_stream_ctrl
    import disp_pkg::*;
#(
    parameter int          FB_BYTES   = 1024,
    parameter logic [15:0] RST_CYCLES = 16'd50000,
    parameter int          FB_AW      = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_req,
    output logic [FB_AW-1:0] fb_addr,
    input  logic [7:0]       fb_data,
    output logic             spi_start,
    output logic [7:0]       spi_data,
    input  logic             spi_done,
    output logic             dc,
    output logic             disp_res_n,
    output logic             init_done,
    output logic             busy,
    output logic             frame_done
);

    state_t      state, state_nx;
    logic [15:0] cnt;
    logic        cnt_tc;
    logic        pending;
    logic        fb_last;
    logic        frame_go;
`ifdef DISP_INIT_SEQ_EN
    logic [4:0]  idx;
    logic        idx_last;
    assign idx_last = (idx == 5'(INIT_LEN - 1));
`endif

    assign cnt_tc     = (cnt == RST_CYCLES - 16'd1);
    assign fb_last    = (fb_addr == FB_AW'(FB_BYTES - 1));
    assign frame_go   = frame_req || pending;
    assign disp_res_n = (state != RST_HOLD);
    assign busy       = (state != READY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RST_HOLD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RST_HOLD:  if (cnt_tc) state_nx = RST_WAIT;
`ifdef DISP_INIT_SEQ_EN
            RST_WAIT:  if (cnt_tc) state_nx = INIT_SEND;
            INIT_SEND: state_nx = INIT_WAIT;
            INIT_WAIT: if (spi_done) state_nx = idx_last ? READY : INIT_SEND;
`else
            RST_WAIT:  if (cnt_tc) state_nx = READY;
`endif
            READY:     if (frame_go) state_nx = FB_FETCH;
            FB_FETCH:  state_nx = FB_SEND;
            FB_SEND:   state_nx = FB_WAIT;
            FB_WAIT:   if (spi_done) state_nx = fb_last ? READY : FB_FETCH;
            default:   state_nx = RST_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            pending    <= 1'b0;
            fb_addr    <= '0;
            spi_start  <= 1'b0;
            spi_data   <= '0;
            dc         <= 1'b0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
`ifdef DISP_INIT_SEQ_EN
            idx        <= '0;
`endif
        end else begin
            spi_start  <= 1'b0;
            frame_done <= 1'b0;

            // A READY cycle always consumes any pending request.
            if (state == READY)  pending <= 1'b0;
            else if (frame_req)  pending <= 1'b1;

            case (state)
                RST_HOLD: cnt <= cnt_tc ? 16'd0 : cnt + 16'd1;
                RST_WAIT: begin
                    cnt <= cnt_tc ? 16'd0 : cnt + 16'd1;
`ifndef DISP_INIT_SEQ_EN
                    if (cnt_tc) init_done <= 1'b1;
`endif
                end
`ifdef DISP_INIT_SEQ_EN
                INIT_SEND: begin
                    dc        <= 1'b0;
                    spi_data  <= init_rom(idx);
                    spi_start <= 1'b1;
                end
                INIT_WAIT: begin
                    if (spi_done) begin
                        idx <= idx + 5'd1;
                        if (idx_last) init_done <= 1'b1;
                    end
                end
`endif
                READY:   if (frame_go) fb_addr <= '0;
                FB_SEND: begin
                    dc        <= 1'b1;
                    spi_data  <= fb_data;
                    spi_start <= 1'b1;
                end
                FB_WAIT: begin
                    if (spi_done) begin
                        if (fb_last) frame_done <= 1'b1;
                        else         fb_addr    <= fb_addr + FB_AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
